pc_watch_tracer: RTL and testbench

//  Synthesizable, parametrised PC watchpoint and trace unit for the pipelined core.

---
 rtl/pc_watch_pkg.sv | 26 ++
 rtl/pc_watch_trace_fifo.sv | 47 ++++
 rtl/pc_watch_tracer.sv | 162 ++++++++++++++++
 tb/tb_pc_watch_tracer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_watch_pkg.sv
// Shared widths, helper functions and the trace record type for the PC watch/trace unit.
package pc_watch_pkg;

  localparam int CYC_W = 32;

  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int rec_width(input int xlen, input int ch_w);
    return ch_w + 2 * xlen + CYC_W;
  endfunction

  localparam int PKG_XLEN   = 32;
  localparam int PKG_NUM_CH = 4;
  localparam int PKG_CH_W   = ch_width(PKG_NUM_CH);

  // Field order matches the packing used by the top level: {ch, pc, data, cycle}
  typedef struct packed {
    logic [PKG_CH_W-1:0] ch;
    logic [PKG_XLEN-1:0] pc;
    logic [PKG_XLEN-1:0] data;
    logic [CYC_W-1:0]    cycle;
  } trace_rec_t;

endpackage

// File: rtl/pc_watch_trace_fifo.sv
// First-word-fall-through trace FIFO with extra-MSB pointers; a push into a full FIFO
// is accepted only when a pop frees a slot in the same cycle.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             pop;
  logic             do_push;

  assign out_valid = (wr_ptr != rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop       = out_valid && out_ready;
  assign do_push   = push && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: only slots between the pointers are ever observed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign out_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/pc_watch_tracer.sv
// PC watchpoint and trace unit: per-channel hit counters plus a trace FIFO of hit records.
// Optional halt request on reaching HALT_CNT hits is enabled with `define PC_WATCH_HALT_EN.
module pc_watch_tracer
  import pc_watch_pkg::*;
#(
  parameter int  XLEN     = 32,
  parameter int  NUM_CH   = 4,
  parameter int  DEPTH    = 16,
  parameter int  CNT_W    = 16,
  parameter int  HALT_CNT = 1,
  localparam int CH_W     = ch_width(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_we,
  input  logic                    cfg_clr,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [XLEN-1:0]         cfg_addr,
  input  logic                    cfg_en,
  input  logic                    ret_valid,
  input  logic [XLEN-1:0]         ret_pc,
  input  logic [XLEN-1:0]         ret_data,
  output logic                    trc_valid,
  input  logic                    trc_ready,
  output logic [CH_W-1:0]         trc_ch,
  output logic [XLEN-1:0]         trc_pc,
  output logic [XLEN-1:0]         trc_data,
  output logic [31:0]             trc_cycle,
  output logic [NUM_CH*CNT_W-1:0] hit_cnt,
  output logic                    trc_overflow,
  output logic                    halt_req,
  input  logic                    halt_ack
);

  localparam int              REC_W    = rec_width(XLEN, CH_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] HALT_VAL = CNT_W'(HALT_CNT);

  logic [XLEN-1:0]  addr_q [NUM_CH];
  logic [NUM_CH-1:0] en_q;
  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] clr_sel;
  logic [NUM_CH-1:0] reach_halt;
  logic [CNT_W-1:0] cnt_q   [NUM_CH];
  logic [CNT_W-1:0] cnt_nxt [NUM_CH];
  logic [CH_W-1:0]  hit_ch;
  logic             any_hit;
  logic [CYC_W-1:0] cyc_q;
  logic             ovf_q;
  logic             fifo_full;
  logic             pop;
  logic [REC_W-1:0] rec_in;
  logic [REC_W-1:0] rec_out;

  // Config writes land after the edge, so a same-cycle retire still sees the old entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) addr_q[i] <= '0;
      en_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_we && (cfg_ch == CH_W'(i))) begin
          addr_q[i] <= cfg_addr;
          en_q[i]   <= cfg_en;
        end
      end
    end
  end

  always_comb begin
    hit     = '0;
    clr_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hit[i]     = ret_valid && en_q[i] && (ret_pc == addr_q[i]);
      clr_sel[i] = cfg_clr && (cfg_ch == CH_W'(i));
    end
  end

  // Descending scan leaves the lowest-index hitting channel in hit_ch
  always_comb begin
    hit_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (hit[i]) hit_ch = CH_W'(i);
    end
  end

  assign any_hit = |hit;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_nxt[i]    = cnt_q[i];
      reach_halt[i] = 1'b0;
      if (clr_sel[i]) begin
        cnt_nxt[i] = '0;
      end else if (hit[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_nxt[i] = cnt_q[i] + CNT_W'(1);
      end
      reach_halt[i] = !clr_sel[i] && hit[i] && (cnt_q[i] != HALT_VAL) && (cnt_nxt[i] == HALT_VAL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_nxt[i];
    end
  end

  assign pop = trc_valid && trc_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cyc_q <= cyc_q + CYC_W'(1);
      if (any_hit && fifo_full && !pop) ovf_q <= 1'b1;
    end
  end

  assign trc_overflow = ovf_q;
  assign rec_in       = {hit_ch, ret_pc, ret_data, cyc_q};

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (any_hit),
    .push_data (rec_in),
    .full      (fifo_full),
    .out_valid (trc_valid),
    .out_ready (trc_ready),
    .out_data  (rec_out)
  );

  assign {trc_ch, trc_pc, trc_data, trc_cycle} = rec_out;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt_out
    assign hit_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end

`ifdef PC_WATCH_HALT_EN
  // Acknowledge takes priority over a new threshold crossing in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_req <= 1'b0;
    end else if (halt_ack) begin
      halt_req <= 1'b0;
    end else if (|reach_halt) begin
      halt_req <= 1'b1;
    end
  end
`else
  logic unused_halt;
  assign unused_halt = ^{halt_ack, reach_halt};
  assign halt_req    = 1'b0;
`endif

endmodule

// File: tb/tb_pc_watch_tracer.sv
// Scoreboard bench for pc_watch_tracer: a cycle model predicts records, counters,
// overflow and halt; records are queued at retire and compared when popped.
module tb_pc_watch_tracer;
  import pc_watch_pkg::*;

  localparam int XLEN     = 32;
  localparam int NUM_CH   = 4;
  localparam int DEPTH    = 8;
  localparam int CNT_W    = 4;
  localparam int HALT_CNT = 2;
  localparam int CH_W     = ch_width(NUM_CH);
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
`ifdef PC_WATCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    cfg_we, cfg_clr, cfg_en;
  logic [CH_W-1:0]         cfg_ch;
  logic [XLEN-1:0]         cfg_addr;
  logic                    ret_valid;
  logic [XLEN-1:0]         ret_pc, ret_data;
  logic                    trc_valid, trc_ready;
  logic [CH_W-1:0]         trc_ch;
  logic [XLEN-1:0]         trc_pc, trc_data;
  logic [31:0]             trc_cycle;
  logic [NUM_CH*CNT_W-1:0] hit_cnt;
  logic                    trc_overflow, halt_req, halt_ack;

  int errors = 0;
  int checks = 0;

  trace_rec_t      exp_q[$];
  logic [XLEN-1:0] m_addr [NUM_CH];
  logic            m_en   [NUM_CH];
  int              m_cnt  [NUM_CH];
  logic            m_ovf;
  logic            m_halt;
  logic [31:0]     m_cyc;

  pc_watch_tracer #(
    .XLEN     (XLEN),
    .NUM_CH   (NUM_CH),
    .DEPTH    (DEPTH),
    .CNT_W    (CNT_W),
    .HALT_CNT (HALT_CNT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_we       (cfg_we),
    .cfg_clr      (cfg_clr),
    .cfg_ch       (cfg_ch),
    .cfg_addr     (cfg_addr),
    .cfg_en       (cfg_en),
    .ret_valid    (ret_valid),
    .ret_pc       (ret_pc),
    .ret_data     (ret_data),
    .trc_valid    (trc_valid),
    .trc_ready    (trc_ready),
    .trc_ch       (trc_ch),
    .trc_pc       (trc_pc),
    .trc_data     (trc_data),
    .trc_cycle    (trc_cycle),
    .hit_cnt      (hit_cnt),
    .trc_overflow (trc_overflow),
    .halt_req     (halt_req),
    .halt_ack     (halt_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [NUM_CH*CNT_W-1:0] modelCnt();
    logic [NUM_CH*CNT_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_CH; i++) r[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
    return r;
  endfunction

  // One clock: predict from current inputs, step the edge, then compare outputs.
  task automatic tick();
    logic [NUM_CH-1:0] hit;
    int                first;
    bit                pop;
    bit                set_halt;
    bit                clr;
    trace_rec_t        rec;
    trace_rec_t        head;
    pop = (exp_q.size() != 0) && trc_ready;
    if (pop) begin
      head = exp_q.pop_front();
      checkOutput("record", {trc_ch, trc_pc, trc_data, trc_cycle}, head);
    end
    first = -1;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      hit[i] = ret_valid && m_en[i] && (ret_pc == m_addr[i]);
      if (hit[i]) first = i;
    end
    if (first >= 0) begin
      rec.ch    = CH_W'(first);
      rec.pc    = ret_pc;
      rec.data  = ret_data;
      rec.cycle = m_cyc;
      if (exp_q.size() < DEPTH) exp_q.push_back(rec);
      else m_ovf = 1'b1;
    end
    set_halt = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      int old;
      old = m_cnt[i];
      clr = cfg_clr && (cfg_ch == CH_W'(i));
      if (clr) m_cnt[i] = 0;
      else if (hit[i] && m_cnt[i] < CNT_MAX) m_cnt[i]++;
      if (!clr && hit[i] && old != HALT_CNT && m_cnt[i] == HALT_CNT) set_halt = 1'b1;
    end
    if (HALT_EN) begin
      if (halt_ack) m_halt = 1'b0;
      else if (set_halt) m_halt = 1'b1;
    end
    if (cfg_we) begin
      m_addr[cfg_ch] = cfg_addr;
      m_en[cfg_ch]   = cfg_en;
    end
    m_cyc++;
    @(posedge clk);
    #1;
    checkOutput("trc_valid", trc_valid, exp_q.size() != 0);
    checkOutput("hit_cnt", hit_cnt, modelCnt());
    checkOutput("trc_overflow", trc_overflow, m_ovf);
    checkOutput("halt_req", halt_req, m_halt);
  endtask

  task automatic applyStimulus(input bit rv, input logic [XLEN-1:0] pc);
    ret_valid = rv;
    ret_pc    = pc;
    ret_data  = $urandom;
    tick();
    ret_valid = 1'b0;
    cfg_we    = 1'b0;
    cfg_clr   = 1'b0;
    halt_ack  = 1'b0;
  endtask

  task automatic setChannel(input int ch, input logic [XLEN-1:0] addr, input bit en);
    cfg_we   = 1'b1;
    cfg_ch   = CH_W'(ch);
    cfg_addr = addr;
    cfg_en   = en;
    applyStimulus(1'b0, '0);
  endtask

  task automatic clearChannel(input int ch);
    cfg_clr = 1'b1;
    cfg_ch  = CH_W'(ch);
    applyStimulus(1'b0, '0);
  endtask

  initial begin
    logic [XLEN-1:0] pcs [3];
    pcs[0] = 'h360; pcs[1] = 'h100; pcs[2] = 'h380;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_clr = 1'b0; cfg_en = 1'b0; cfg_ch = '0; cfg_addr = '0;
    ret_valid = 1'b0; ret_pc = '0; ret_data = '0; trc_ready = 1'b0; halt_ack = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_addr[i] = '0; m_en[i] = 1'b0; m_cnt[i] = 0;
    end
    m_ovf = 1'b0; m_halt = 1'b0; m_cyc = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_valid", trc_valid, 1'b0);
    checkOutput("reset_hit_cnt", hit_cnt, '0);
    checkOutput("reset_overflow", trc_overflow, 1'b0);
    checkOutput("reset_halt", halt_req, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] basic hits on ch0");
    trc_ready = 1'b1;
    setChannel(0, 'h360, 1'b1);
    repeat (3) applyStimulus(1'b1, 'h360);
    repeat (2) applyStimulus(1'b0, '0);
    checkOutput("t1_cnt0", hit_cnt[CNT_W-1:0], 3);
    halt_ack = 1'b1;
    applyStimulus(1'b0, '0);

    $display("[TB] two channels on one PC");
    setChannel(1, 'h100, 1'b1);
    setChannel(2, 'h100, 1'b1);
    applyStimulus(1'b1, 'h100);
    repeat (2) applyStimulus(1'b0, '0);
    checkOutput("t2_cnt1", hit_cnt[CNT_W +: CNT_W], 1);
    checkOutput("t2_cnt2", hit_cnt[2*CNT_W +: CNT_W], 1);

    $display("[TB] overflow with consumer stalled");
    setChannel(3, 'h380, 1'b1);
    trc_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1'b1, pcs[i % 3]);
    checkOutput("t3_overflow", trc_overflow, 1'b1);
    trc_ready = 1'b1;
    repeat (DEPTH + 2) applyStimulus(1'b0, '0);
    checkOutput("t3_empty", trc_valid, 1'b0);

    $display("[TB] push and pop on a full FIFO");
    trc_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, pcs[i % 3]);
    trc_ready = 1'b1;
    applyStimulus(1'b1, 'h100);
    repeat (DEPTH) applyStimulus(1'b0, '0);
    checkOutput("t4_empty", trc_valid, 1'b0);

    $display("[TB] saturation, clear priority, config timing");
    clearChannel(0);
    repeat (20) applyStimulus(1'b1, 'h360);
    checkOutput("t5_saturate", hit_cnt[CNT_W-1:0], CNT_MAX);
    cfg_clr = 1'b1; cfg_ch = '0;
    applyStimulus(1'b1, 'h360);
    checkOutput("t5_clear_wins", hit_cnt[CNT_W-1:0], 0);
    cfg_we = 1'b1; cfg_ch = '0; cfg_addr = 'h200; cfg_en = 1'b1;
    applyStimulus(1'b1, 'h200);
    checkOutput("t5_cfg_same_cycle", hit_cnt[CNT_W-1:0], 0);
    applyStimulus(1'b1, 'h200);
    checkOutput("t5_cfg_next_cycle", hit_cnt[CNT_W-1:0], 1);
    repeat (3) applyStimulus(1'b0, '0);

    $display("[TB] halt request");
    halt_ack = 1'b1;
    applyStimulus(1'b0, '0);
    clearChannel(3);
    setChannel(3, 'h400, 1'b1);
    applyStimulus(1'b1, 'h400);
    checkOutput("t6_halt_first", halt_req, 1'b0);
    applyStimulus(1'b1, 'h400);
    checkOutput("t6_halt_second", halt_req, HALT_EN);
    halt_ack = 1'b1;
    applyStimulus(1'b0, '0);
    checkOutput("t6_halt_ack", halt_req, 1'b0);
    clearChannel(3);
    applyStimulus(1'b1, 'h400);
    halt_ack = 1'b1;
    applyStimulus(1'b1, 'h400);
    checkOutput("t6_ack_wins", halt_req, 1'b0);
    repeat (4) applyStimulus(1'b0, '0);
    checkOutput("final_empty", trc_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
